// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the multi-channel DC motor controller:
// the per-channel FSM state encoding, the H-bridge drive codes and two
// small helpers for duty clamping and direction-to-code mapping.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_DEAD = 2'd3
  } ch_state_e;

  typedef logic [1:0] hb_code_t;

  // IN1/IN2 codes presented to the H-bridge driver
  localparam hb_code_t FWD   = 2'b10;
  localparam hb_code_t REV   = 2'b01;
  localparam hb_code_t BRAKE = 2'b11;

  // Any requested duty above the frame length means 100 %
  function automatic logic [7:0] clamp_duty(input logic [7:0] duty,
                                            input logic [7:0] period);
    return (duty > period) ? period : duty;
  endfunction

  function automatic hb_code_t dir_code(input logic dir_rev);
    return dir_rev ? REV : FWD;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: soft-start ramp FSM (IDLE/RAMP/HOLD/DEAD) with a
// brake interval on every direction reversal. Consumes the shared PWM
// counter and ramp tick from the top level.
module motor_channel
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_PERIOD  = 10,
  parameter int DEAD_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       run_i,
  input  logic       dir_i,
  input  logic [7:0] duty_i,
  input  logic [7:0] pwm_cnt_i,
  input  logic       ramp_tick_i,
  output logic       pwm_o,
  output hb_code_t   hb_o,
  output logic       busy_o
);

  localparam logic [7:0]  PERIOD_C  = 8'(PWM_PERIOD);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

  ch_state_e   state_q, state_d;
  logic [7:0]  cur_duty_q, cur_duty_d;
  logic        act_dir_q, act_dir_d;
  logic [15:0] dead_cnt_q, dead_cnt_d;
  logic        pwm_q;
  hb_code_t    hb_q;
  logic        busy_q;

  logic [7:0]  target;
  logic        reversing;
  logic [7:0]  ramp_tgt;

  assign target    = clamp_duty(duty_i, PERIOD_C);
  assign reversing = (dir_i != act_dir_q);
  // A pending reversal steers the ramp to zero; toggling dir back
  // before DEAD restores the real target automatically.
  assign ramp_tgt  = reversing ? 8'd0 : target;

  // Next-state logic for the channel FSM, duty ramp and dead-time counter
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch;
    // combinational logic uses blocking '=', the register block below uses '<='.
    state_d    = state_q;
    cur_duty_d = cur_duty_q;
    act_dir_d  = act_dir_q;
    dead_cnt_d = dead_cnt_q;
    if (!run_i) begin
      // Stop is immediate: no ramp-down
      state_d    = ST_IDLE;
      cur_duty_d = 8'd0;
      dead_cnt_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cur_duty_d = 8'd0;
          act_dir_d  = dir_i;
          state_d    = ST_RAMP;
        end
        ST_RAMP: begin
          if (reversing && cur_duty_q == 8'd0) begin
            state_d    = ST_DEAD;
            dead_cnt_d = 16'd0;
          end else if (cur_duty_q == ramp_tgt) begin
            state_d = ST_HOLD;
          end else if (ramp_tick_i) begin
            cur_duty_d = (cur_duty_q < ramp_tgt) ? cur_duty_q + 8'd1
                                                 : cur_duty_q - 8'd1;
          end
        end
        ST_HOLD: begin
          if (reversing && cur_duty_q == 8'd0) begin
            state_d    = ST_DEAD;
            dead_cnt_d = 16'd0;
          end else if (cur_duty_q != ramp_tgt) begin
            state_d = ST_RAMP;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q == DEAD_LAST) begin
            act_dir_d  = dir_i;
            state_d    = ST_RAMP;
            dead_cnt_d = 16'd0;
          end else begin
            dead_cnt_d = dead_cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers plus registered outputs; reset forces brake/idle at once
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      cur_duty_q <= 8'd0;
      act_dir_q  <= 1'b0;
      dead_cnt_q <= 16'd0;
      pwm_q      <= 1'b0;
      hb_q       <= BRAKE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_duty_q <= cur_duty_d;
      act_dir_q  <= act_dir_d;
      dead_cnt_q <= dead_cnt_d;
      // PWM compares the current frame position with the present duty;
      // run gating makes a stop visible on the very next cycle.
      pwm_q      <= run_i && (state_q == ST_RAMP || state_q == ST_HOLD) &&
                    (pwm_cnt_i < cur_duty_q);
      // Bridge code and busy follow the state being entered, so they line
      // up with state_q for the whole time the FSM stays there.
      hb_q       <= (state_d == ST_RAMP || state_d == ST_HOLD) ?
                    dir_code(act_dir_d) : BRAKE;
      busy_q     <= (state_d == ST_RAMP || state_d == ST_DEAD);
    end
  end

  assign pwm_o  = pwm_q;
  assign hb_o   = hb_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/multi_dc_motor_controller.sv
// Top level: shared PWM frame counter and ramp prescaler, driving N_CH
// independent motor_channel instances.
module multi_dc_motor_controller
  import motor_ctrl_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int PWM_PERIOD  = 10,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 50
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic [N_CH-1:0]     run,
  input  logic [N_CH-1:0]     dir,
  input  logic [8*N_CH-1:0]   duty,
  output logic [N_CH-1:0]     pwm_out,
  output logic [2*N_CH-1:0]   in1_in2,
  output logic [N_CH-1:0]     busy
);

  localparam logic [7:0]  PWM_LAST  = 8'(PWM_PERIOD - 1);
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);

  logic [7:0]  pwm_cnt_q;
  logic [15:0] presc_q;
  logic        ramp_tick;

  // Shared PWM frame counter: 0 .. PWM_PERIOD-1, then wrap
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pwm_cnt_q <= 8'd0;
    end else if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  // Shared ramp prescaler: 0 .. RAMP_DIV-1, tick in the wrap cycle
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc_q <= 16'd0;
    end else if (presc_q == RAMP_LAST) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  assign ramp_tick = (presc_q == RAMP_LAST);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    motor_channel #(
      .PWM_PERIOD  (PWM_PERIOD),
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset_p     (reset_p),
      .run_i       (run[k]),
      .dir_i       (dir[k]),
      .duty_i      (duty[8*k +: 8]),
      .pwm_cnt_i   (pwm_cnt_q),
      .ramp_tick_i (ramp_tick),
      .pwm_o       (pwm_out[k]),
      .hb_o        (in1_in2[2*k +: 2]),
      .busy_o      (busy[k])
    );
  end

endmodule

// File: tb/tb_multi_dc_motor_controller.sv
// Directed bench for multi_dc_motor_controller with PWM_PERIOD=10,
// RAMP_DIV=2, DEAD_CYCLES=4, N_CH=2.
module tb_multi_dc_motor_controller;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [1:0]  run;
  logic [1:0]  dir;
  logic [15:0] duty;
  logic [1:0]  pwm_out;
  logic [3:0]  in1_in2;
  logic [1:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;

  multi_dc_motor_controller #(
    .N_CH        (2),
    .PWM_PERIOD  (10),
    .RAMP_DIV    (2),
    .DEAD_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .run     (run),
    .dir     (dir),
    .duty    (duty),
    .pwm_out (pwm_out),
    .in1_in2 (in1_in2),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count high cycles of each pwm_out bit over n consecutive samples
  task automatic count_high(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out[0]) c0++;
      if (pwm_out[1]) c1++;
    end
  endtask

  // Wait (bounded) until busy[ch] drops, i.e. the channel reached HOLD
  task automatic wait_settle(input int ch, input int max_cyc,
                             output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < max_cyc && !ok) begin
      @(negedge clk);
      cyc++;
      if (!busy[ch]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    run     = 2'b00;
    dir     = 2'b00;
    duty    = 16'h0000;
    #3;
    n_checks++;
    if (pwm_out !== 2'b00 || in1_in2 !== 4'b1111 || busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_asserted: pwm=%b hb=%b busy=%b, want 00 1111 00",
               pwm_out, in1_in2, busy);
    end
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== 2'b00 || in1_in2 !== 4'b1111 || busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: pwm=%b hb=%b busy=%b, want 00 1111 00",
                 i, pwm_out, in1_in2, busy);
      end
    end
  endtask

  task automatic test_ramp_hold();
    int cyc, c0, c1;
    bit ok;
    run[0]     = 1'b1;
    dir[0]     = 1'b0;
    duty[7:0]  = 8'd5;
    wait_settle(0, 40, cyc, ok);
    n_checks++;
    if (!ok || cyc < 11 || cyc > 12) begin
      n_fail++;
      $display("FAIL ramp_up_time: settled=%0d after %0d cycles, want 1 after 11..12",
               ok, cyc);
    end
    n_checks++;
    if (in1_in2 !== 4'b1110) begin
      n_fail++;
      $display("FAIL hold_fwd_code: hb=%b, want 1110", in1_in2);
    end
    count_high(30, c0, c1);
    n_checks++;
    if (c0 != 15) begin
      n_fail++;
      $display("FAIL hold_duty5: ch0 high %0d of 30, want 15", c0);
    end
    n_checks++;
    if (c1 != 0) begin
      n_fail++;
      $display("FAIL ch1_idle_pwm: ch1 high %0d of 30, want 0", c1);
    end
  endtask

  task automatic test_reversal();
    int fwd, brk, cyc, c0, c1;
    bit seen_rev, busy_gap, done;
    fwd = 0; brk = 0; cyc = 0;
    seen_rev = 1'b0; busy_gap = 1'b0; done = 1'b0;
    dir[0] = 1'b1;
    while (cyc < 80 && !done) begin
      @(negedge clk);
      cyc++;
      case (in1_in2[1:0])
        2'b10:   if (!seen_rev && brk == 0) fwd++;
        2'b11:   brk++;
        2'b01:   seen_rev = 1'b1;
        default: ;
      endcase
      if (!busy[0]) begin
        if (seen_rev) done = 1'b1;
        else busy_gap = 1'b1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL reversal_done: no HOLD in reverse within 80 cycles");
    end
    n_checks++;
    if (busy_gap) begin
      n_fail++;
      $display("FAIL reversal_busy: busy dropped before reverse ramp completed");
    end
    n_checks++;
    if (fwd < 10 || fwd > 11) begin
      n_fail++;
      $display("FAIL ramp_down_time: fwd cycles %0d, want 10..11", fwd);
    end
    n_checks++;
    if (brk != 4) begin
      n_fail++;
      $display("FAIL dead_time: brake cycles %0d, want 4", brk);
    end
    n_checks++;
    if (in1_in2[1:0] !== 2'b01) begin
      n_fail++;
      $display("FAIL rev_code: hb0=%b, want 01", in1_in2[1:0]);
    end
    count_high(30, c0, c1);
    n_checks++;
    if (c0 != 15) begin
      n_fail++;
      $display("FAIL rev_hold_duty5: ch0 high %0d of 30, want 15", c0);
    end
  endtask

  task automatic test_clamp_and_zero();
    int cyc, c0, c1;
    bit ok;
    run[1]     = 1'b1;
    dir[1]     = 1'b0;
    duty[15:8] = 8'd200;
    wait_settle(1, 60, cyc, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL clamp_settle: ch1 not in HOLD after %0d cycles", cyc);
    end
    count_high(30, c0, c1);
    n_checks++;
    if (c1 != 30) begin
      n_fail++;
      $display("FAIL clamp_full_on: ch1 high %0d of 30, want 30", c1);
    end
    n_checks++;
    if (c0 != 15) begin
      n_fail++;
      $display("FAIL independence: ch0 high %0d of 30, want 15", c0);
    end
    n_checks++;
    if (in1_in2 !== 4'b1001) begin
      n_fail++;
      $display("FAIL both_codes: hb=%b, want 1001", in1_in2);
    end
    duty[15:8] = 8'd0;
    wait_settle(1, 60, cyc, ok);
    count_high(30, c0, c1);
    n_checks++;
    if (!ok || c1 != 0 || in1_in2[3:2] !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_duty: settled=%0d high=%0d hb1=%b, want 1 0 10",
               ok, c1, in1_in2[3:2]);
    end
  endtask

  task automatic test_run_stop();
    int cyc;
    bit ok;
    duty[15:8] = 8'd200;
    wait_settle(1, 60, cyc, ok);
    run[0] = 1'b0;
    @(negedge clk);
    run[0]    = 1'b1;
    dir[0]    = 1'b0;
    duty[7:0] = 8'd5;
    repeat (7) @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b1 || in1_in2[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_ramp: busy0=%b hb0=%b, want 1 10", busy[0], in1_in2[1:0]);
    end
    run[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pwm_out[0] !== 1'b0 || in1_in2[1:0] !== 2'b11 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_next_cycle: pwm0=%b hb0=%b busy0=%b, want 0 11 0",
               pwm_out[0], in1_in2[1:0], busy[0]);
    end
    n_checks++;
    if (!ok || pwm_out[1] !== 1'b1 || in1_in2[3:2] !== 2'b10 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ch1_unaffected: settled=%0d pwm1=%b hb1=%b busy1=%b, want 1 1 10 0",
               ok, pwm_out[1], in1_in2[3:2], busy[1]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out[0] !== 1'b0 || in1_in2[1:0] !== 2'b11) begin
        n_fail++;
        $display("FAIL stopped_idle cycle %0d: pwm0=%b hb0=%b, want 0 11",
                 i, pwm_out[0], in1_in2[1:0]);
      end
    end
  endtask

  task automatic test_reset_in_dead();
    int cyc, c0, c1;
    bit ok, hit;
    run[0]    = 1'b1;
    dir[0]    = 1'b0;
    duty[7:0] = 8'd5;
    wait_settle(0, 40, cyc, ok);
    dir[0] = 1'b1;
    hit = 1'b0;
    cyc = 0;
    while (cyc < 40 && !hit) begin
      @(negedge clk);
      cyc++;
      if (in1_in2[1:0] == 2'b11) hit = 1'b1;
    end
    n_checks++;
    if (!ok || !hit) begin
      n_fail++;
      $display("FAIL reach_dead: hold=%0d dead=%0d, want 1 1", ok, hit);
    end
    #2 reset_p = 1'b1;
    #1;
    n_checks++;
    if (pwm_out !== 2'b00 || in1_in2 !== 4'b1111 || busy !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: pwm=%b hb=%b busy=%b, want 00 1111 00",
               pwm_out, in1_in2, busy);
    end
    @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pwm_out !== 2'b00 || in1_in2 !== 4'b1001 || busy !== 2'b11) begin
      n_fail++;
      $display("FAIL rerun_start: pwm=%b hb=%b busy=%b, want 00 1001 11",
               pwm_out, in1_in2, busy);
    end
    wait_settle(0, 40, cyc, ok);
    n_checks++;
    if (!ok || cyc < 10 || cyc > 11) begin
      n_fail++;
      $display("FAIL rerun_from_zero: settled=%0d after %0d cycles, want 1 after 10..11",
               ok, cyc);
    end
    count_high(30, c0, c1);
    n_checks++;
    if (c0 != 15) begin
      n_fail++;
      $display("FAIL rerun_duty5: ch0 high %0d of 30, want 15", c0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_hold();
    test_reversal();
    test_clamp_and_zero();
    test_run_stop();
    test_reset_in_dead();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
